opmem_fetch: RTL and testbench

//  Read-side controller for the 16x8 op memory: fetches ops sequentially from a start address,

---
 rtl/opmem_fetch.sv | 117 +++++++++++
 tb/tb_opmem_fetch.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/opmem_fetch.sv
// opmem_fetch: sequential op fetch from the opram, hiding the registered read latency behind a prefetch FIFO
module opmem_fetch #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int READ_LAT = 2,
    parameter int FIFO_DEPTH = 4,
    parameter logic [DATA_W-1:0] HALT_OP = '1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              abort,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [ADDR_W-1:0] mem_ad,
    output logic              mem_ce,
    output logic              mem_oce,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_out,
    output logic [ADDR_W-1:0] op_addr,
    output logic              busy,
    output logic              done
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + READ_LAT) + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FLUSH} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [READ_LAT-1:0] pv_q, pv_d;
    logic [ADDR_W-1:0] pa_q [READ_LAT];
    logic [ADDR_W-1:0] pa_d [READ_LAT];
    logic [PW:0]       rd_q, rd_d, wr_q, wr_d;
    logic              done_q, done_d, oce_q;
    logic [DATA_W-1:0] fifo_op_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_ad_q [FIFO_DEPTH];
    logic [CW-1:0]     inflight;
    logic [PW:0]       fill;
    logic [DATA_W-1:0] head_op;
    logic [ADDR_W-1:0] head_ad;
    logic              fifo_empty, push, pop, issue, halt_in, halt_out, live;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LAT; i++) inflight = inflight + CW'(pv_q[i]);
        fill = wr_q - rd_q;
        fifo_empty = wr_q == rd_q;
        head_op = fifo_op_q[rd_q[PW-1:0]];
        head_ad = fifo_ad_q[rd_q[PW-1:0]];
        live = state_q == FETCH || state_q == DRAIN;
        pop = !fifo_empty && op_ready;
        push = pv_q[READ_LAT-1] && state_q == FETCH && !abort;
        halt_in = push && mem_dout == HALT_OP;
        issue = state_q == FETCH && !abort && !halt_in && (inflight + CW'(fill) < CW'(FIFO_DEPTH));
        halt_out = state_q == DRAIN && !abort && pop && head_op == HALT_OP;
        pv_d[0] = issue;
        pa_d[0] = ptr_q;
        for (int i = 1; i < READ_LAT; i++) begin
            pv_d[i] = pv_q[i-1];
            pa_d[i] = pa_q[i-1];
        end
        // the halt return kills every younger read still in flight
        if (halt_in) pv_d = '0;
        ptr_d = state_q == IDLE && start ? start_addr : issue ? ptr_q + 1'b1 : ptr_q;
        wr_d = push ? wr_q + 1'b1 : wr_q;
        rd_d = live && abort ? wr_q : pop ? rd_q + 1'b1 : rd_q;
        done_d = halt_out;
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? FETCH : IDLE;
            FETCH:   state_d = abort ? FLUSH : halt_in ? DRAIN : FETCH;
            DRAIN:   state_d = abort ? FLUSH : halt_out ? IDLE : DRAIN;
            FLUSH:   state_d = inflight == '0 ? IDLE : FLUSH;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            pv_q    <= '0;
            for (int i = 0; i < READ_LAT; i++) pa_q[i] <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            done_q  <= 1'b0;
            oce_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            pv_q    <= pv_d;
            pa_q    <= pa_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            done_q  <= done_d;
            oce_q   <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_op_q[wr_q[PW-1:0]] <= mem_dout;
            fifo_ad_q[wr_q[PW-1:0]] <= pa_q[READ_LAT-1];
        end
    end

    assign mem_ad   = ptr_q;
    assign mem_ce   = issue;
    assign mem_oce  = oce_q;
    assign op_valid = !fifo_empty;
    assign op_out   = fifo_empty ? '0 : head_op;
    assign op_addr  = fifo_empty ? '0 : head_ad;
    assign busy     = state_q != IDLE;
    assign done     = done_q;
endmodule

// File: tb/tb_opmem_fetch.sv
// tb_opmem_fetch: directed and random runs against a sequential-read scoreboard of the op memory
module tb_opmem_fetch;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int RL = 2;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          op_ready = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [DW-1:0] mem_dout;
    logic [AW-1:0] mem_ad, op_addr;
    logic          mem_ce, mem_oce, op_valid, busy, done;
    logic [DW-1:0] op_out;

    logic [DW-1:0] mem [16];
    logic [DW-1:0] rd1;
    logic [AW+DW-1:0] exp_q [$];
    int checks = 0;
    int errors = 0;
    int cyc_n = 0;
    int start_cyc, done_cnt, halt_cyc, first_valid, first_acc, last_acc, n_acc, issued;
    bit hi_issue, stalled;
    logic [DW-1:0] prev_op;
    logic [AW-1:0] prev_ad;

    opmem_fetch dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .abort(abort),
        .mem_dout(mem_dout), .mem_ad(mem_ad), .mem_ce(mem_ce), .mem_oce(mem_oce),
        .op_valid(op_valid), .op_ready(op_ready), .op_out(op_out), .op_addr(op_addr),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_ce) rd1 <= mem[mem_ad];
        if (mem_oce) mem_dout <= rd1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        if (mem_ce) begin
            issued++;
            if (mem_ad >= 4'd6) hi_issue = 1'b1;
        end
        if (first_valid < 0 && op_valid) first_valid = cyc_n;
        if (stalled) begin
            chk("stall_valid", op_valid, 1);
            chk("stall_data", {op_addr, op_out}, {prev_ad, prev_op});
        end
        if (done) begin
            done_cnt++;
            chk("done_timing", cyc_n - halt_cyc, 1);
            chk("done_idle", busy, 0);
        end
        if (op_valid && op_ready) begin
            chk("op_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) chk("op", {op_addr, op_out}, exp_q.pop_front());
            if (op_out == 8'hFF) halt_cyc = cyc_n;
            if (first_acc < 0) first_acc = cyc_n;
            last_acc = cyc_n;
            n_acc++;
        end
        stalled = op_valid && !op_ready;
        prev_op = op_out;
        prev_ad = op_addr;
        @(posedge clk);
        cyc_n++;
        #1;
    endtask

    task automatic run_start(input logic [AW-1:0] a);
        logic [AW-1:0] p;
        exp_q.delete();
        p = a;
        for (int k = 0; k < 16; k++) begin
            exp_q.push_back({p, mem[p]});
            if (mem[p] == 8'hFF) break;
            p = p + 1'b1;
        end
        done_cnt = 0; halt_cyc = -100; first_valid = -1; first_acc = -1;
        n_acc = 0; issued = 0; hi_issue = 1'b0;
        start_addr = a;
        start = 1'b1;
        cycle();
        start = 1'b0;
        start_cyc = cyc_n;
    endtask

    task automatic finish_run(input bit rnd);
        for (int k = 0; k < 300 && done_cnt == 0; k++) begin
            op_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cycle();
        end
        chk("done_seen", done_cnt, 1);
        chk("queue_empty", exp_q.size(), 0);
        cycle();
        chk("post_valid", op_valid, 0);
        chk("post_busy", busy, 0);
        chk("done_once", done_cnt, 1);
    endtask

    initial begin
        #(2_000_000);
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        #1;
        chk("rst_ce", mem_ce, 0);
        chk("rst_oce", mem_oce, 0);
        chk("rst_valid", op_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_out", {op_addr, op_out, mem_ad}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cycle();
        chk("oce_after_rst", mem_oce, 1);

        // T1: short run, latency and back-to-back delivery
        for (int k = 0; k < 16; k++) mem[k] = 8'h55;
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'hFF;
        op_ready = 1'b1;
        run_start(4'h0);
        finish_run(1'b0);
        chk("t1_latency", first_valid - start_cyc, RL + 1);
        chk("t1_consec", last_acc - first_acc, 3);
        chk("t1_nacc", n_acc, 4);
        chk("t1_no_hi_issue", hi_issue, 0);

        // T2: address wrap, start and abort together in IDLE
        mem[14] = 8'h01; mem[15] = 8'h02; mem[0] = 8'hFF;
        abort = 1'b1;
        run_start(4'hE);
        abort = 1'b0;
        finish_run(1'b0);
        chk("t2_nacc", n_acc, 3);

        // T3: long consumer stall
        for (int k = 0; k < 15; k++) mem[k] = 8'(k + 8'h10);
        mem[15] = 8'hFF;
        op_ready = 1'b1;
        run_start(4'h0);
        for (int k = 0; k < 20 && n_acc < 3; k++) cycle();
        op_ready = 1'b0;
        for (int k = 0; k < 10; k++) cycle();
        chk("t3_outstanding", issued - n_acc, FD);
        chk("t3_ce_idle", mem_ce, 0);
        finish_run(1'b0);
        chk("t3_nacc", n_acc, 16);

        // T4: abort right after the first accepted op
        for (int k = 0; k < 15; k++) mem[k] = 8'(k + 8'h20);
        mem[15] = 8'hFF;
        op_ready = 1'b1;
        run_start(4'h2);
        for (int k = 0; k < 20 && n_acc < 1; k++) cycle();
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        exp_q.delete();
        chk("t4_valid_drop", op_valid, 0);
        for (int k = 0; k < RL + 1 && busy; k++) cycle();
        chk("t4_busy_fall", busy, 0);
        chk("t4_no_done", done_cnt, 0);
        mem[9] = 8'hFF;
        run_start(4'h5);
        finish_run(1'b0);
        chk("t4_restart_nacc", n_acc, 5);

        // T5: asynchronous reset mid-run
        for (int k = 0; k < 16; k++) mem[k] = 8'h55;
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'hFF;
        op_ready = 1'b1;
        run_start(4'h0);
        repeat (4) cycle();
        #3;
        rst = 1'b1;
        #1;
        chk("t5_ce", mem_ce, 0);
        chk("t5_ad", mem_ad, 0);
        chk("t5_oce", mem_oce, 0);
        chk("t5_valid", op_valid, 0);
        chk("t5_out", {op_addr, op_out}, 0);
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        stalled = 1'b0;
        exp_q.delete();
        run_start(4'h0);
        finish_run(1'b0);
        chk("t5_latency", first_valid - start_cyc, RL + 1);
        chk("t5_nacc", n_acc, 4);

        // T6: random memory, start address and consumer backpressure
        for (int r = 0; r < 200; r++) begin
            for (int k = 0; k < 16; k++) mem[k] = 8'($urandom_range(0, 254));
            mem[$urandom_range(0, 15)] = 8'hFF;
            op_ready = 1'($urandom_range(0, 1));
            run_start(4'($urandom_range(0, 15)));
            start_addr = 4'($urandom_range(0, 15));
            start = 1'b1;
            cycle();
            start = 1'b0;
            finish_run(1'b1);
            repeat ($urandom_range(0, 2)) cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
